// File: rtl/multiport_regfile_sb_pkg.sv
// Shared defaults and packed-port slicing helpers for the multiport register file.
package regfile_pkg;

   localparam int unsigned DATA_W_DEF = 32;
   localparam int unsigned ADDR_W_DEF = 5;
   localparam int unsigned DEPTH_DEF  = 1 << ADDR_W_DEF;

   localparam logic [ADDR_W_DEF-1:0] ZERO_REG = '0;

   // Widest flattened port bus and widest single field the helpers handle.
   localparam int unsigned MAX_VEC_W   = 2048;
   localparam int unsigned MAX_FIELD_W = 64;

   // Field idx of width w from a flattened port bus; caller narrows to w bits.
   function automatic logic [MAX_FIELD_W-1:0] port_addr(input logic [MAX_VEC_W-1:0] vec,
                                                        input int unsigned idx,
                                                        input int unsigned w);
      return MAX_FIELD_W'(vec >> (idx * w));
   endfunction

   function automatic logic [MAX_FIELD_W-1:0] port_data(input logic [MAX_VEC_W-1:0] vec,
                                                        input int unsigned idx,
                                                        input int unsigned w);
      return MAX_FIELD_W'(vec >> (idx * w));
   endfunction

endpackage

// File: rtl/multiport_regfile_sb_if.sv
// Decode/writeback-facing bus of the multiport register file with scoreboard.
interface multiport_regfile_sb_if #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 5,
   parameter int unsigned NUM_RD = 2,
   parameter int unsigned NUM_WR = 1
);
   localparam int unsigned DEPTH = 1 << ADDR_W;

   logic [NUM_WR-1:0]        wr_en;
   logic [NUM_WR*ADDR_W-1:0] wr_addr;
   logic [NUM_WR*DATA_W-1:0] wr_data;
   logic [NUM_RD*ADDR_W-1:0] rd_addr;
   logic [NUM_RD*DATA_W-1:0] rd_data;
   logic [NUM_RD-1:0]        rd_busy;
   logic                     iss_en;
   logic [ADDR_W-1:0]        iss_addr;
   logic [DEPTH-1:0]         busy_vec;

   modport master (
      output wr_en, wr_addr, wr_data, rd_addr, iss_en, iss_addr,
      input  rd_data, rd_busy, busy_vec
   );

   modport slave (
      input  wr_en, wr_addr, wr_data, rd_addr, iss_en, iss_addr,
      output rd_data, rd_busy, busy_vec
   );
endinterface

// File: rtl/multiport_regfile_sb_scoreboard.sv
// Busy-bit scoreboard: issue sets, writeback clears, issue wins on collision.
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter int unsigned ADDR_W = ADDR_W_DEF,
   parameter int unsigned NUM_RD = 2,
   parameter int unsigned NUM_WR = 1,
   localparam int unsigned DEPTH = 1 << ADDR_W
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_WR-1:0]        wr_en,
   input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
   input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
   input  logic                     iss_en,
   input  logic [ADDR_W-1:0]        iss_addr,
   output logic [DEPTH-1:0]         busy_vec,
   output logic [NUM_RD-1:0]        rd_busy_c
);

   logic [DEPTH-1:0] busy_nxt;

   // Next busy state: clear on any write, then a new producer re-marks its register.
   always_comb begin
      logic [ADDR_W-1:0] wa;
      busy_nxt = busy_vec;
      wa       = '0;
      for (int unsigned i = 0; i < NUM_WR; i++) begin
         wa = ADDR_W'(port_addr(MAX_VEC_W'(wr_addr), i, ADDR_W));
         if (wr_en[i]) busy_nxt[wa] = 1'b0;
      end
      if (iss_en && iss_addr != ADDR_W'(ZERO_REG)) busy_nxt[iss_addr] = 1'b1;
   end

   // Scoreboard state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) busy_vec <= '0;
      else     busy_vec <= busy_nxt;
   end

   // Per read port busy lookup from registered state only.
   always_comb begin
      logic [ADDR_W-1:0] ra;
      rd_busy_c = '0;
      ra        = '0;
      for (int unsigned k = 0; k < NUM_RD; k++) begin
         ra           = ADDR_W'(port_addr(MAX_VEC_W'(rd_addr), k, ADDR_W));
         rd_busy_c[k] = (ra != ADDR_W'(ZERO_REG)) && busy_vec[ra];
      end
   end

endmodule

// File: rtl/multiport_regfile_sb.sv
// NUM_RD-read / NUM_WR-write register file with integrated busy scoreboard.
// Optional write-through forwarding to the read ports: define REGFILE_BYPASS_EN.
module multiport_regfile_sb
   import regfile_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEF,
   parameter int unsigned ADDR_W = ADDR_W_DEF,
   parameter int unsigned NUM_RD = 2,
   parameter int unsigned NUM_WR = 1
) (
   input logic                  clk,
   input logic                  rst,
   multiport_regfile_sb_if.slave bus
);

   localparam int unsigned DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0]        mem [DEPTH];
   logic [ADDR_W-1:0]        wr_addr_a [NUM_WR];
   logic [DATA_W-1:0]        wr_data_a [NUM_WR];
   logic [ADDR_W-1:0]        rd_addr_a [NUM_RD];
   logic [NUM_RD*DATA_W-1:0] rd_data_c;
   logic [NUM_RD-1:0]        rd_busy_c;
   logic [NUM_RD-1:0]        sb_rd_busy_c;
   logic [DEPTH-1:0]         busy_vec;

   // Unpack the flattened port buses.
   always_comb begin
      for (int unsigned i = 0; i < NUM_WR; i++) begin
         wr_addr_a[i] = ADDR_W'(port_addr(MAX_VEC_W'(bus.wr_addr), i, ADDR_W));
         wr_data_a[i] = DATA_W'(port_data(MAX_VEC_W'(bus.wr_data), i, DATA_W));
      end
      for (int unsigned k = 0; k < NUM_RD; k++) begin
         rd_addr_a[k] = ADDR_W'(port_addr(MAX_VEC_W'(bus.rd_addr), k, ADDR_W));
      end
   end

   // Data array; later (higher-index) ports override earlier ones on the same address.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned r = 0; r < DEPTH; r++) mem[ADDR_W'(r)] <= '0;
      end else begin
         for (int unsigned i = 0; i < NUM_WR; i++) begin
            if (bus.wr_en[i] && wr_addr_a[i] != ADDR_W'(ZERO_REG))
               mem[wr_addr_a[i]] <= wr_data_a[i];
         end
      end
   end

   // Combinational read, register 0 hardwired to zero, optional forwarding.
   always_comb begin
      logic [ADDR_W-1:0] ra;
      rd_data_c = '0;
      rd_busy_c = sb_rd_busy_c;
      ra        = '0;
      for (int unsigned k = 0; k < NUM_RD; k++) begin
         ra = rd_addr_a[k];
         rd_data_c[k*DATA_W +: DATA_W] = (ra == ADDR_W'(ZERO_REG)) ? '0 : mem[ra];
`ifdef REGFILE_BYPASS_EN
         for (int unsigned i = 0; i < NUM_WR; i++) begin
            if (ra != ADDR_W'(ZERO_REG) && bus.wr_en[i] && wr_addr_a[i] == ra) begin
               rd_data_c[k*DATA_W +: DATA_W] = wr_data_a[i];
               rd_busy_c[k] = bus.iss_en && (bus.iss_addr == ra);
            end
         end
`endif
      end
   end

   regfile_scoreboard #(
      .ADDR_W (ADDR_W),
      .NUM_RD (NUM_RD),
      .NUM_WR (NUM_WR)
   ) u_scoreboard (
      .clk       (clk),
      .rst       (rst),
      .wr_en     (bus.wr_en),
      .wr_addr   (bus.wr_addr),
      .rd_addr   (bus.rd_addr),
      .iss_en    (bus.iss_en),
      .iss_addr  (bus.iss_addr),
      .busy_vec  (busy_vec),
      .rd_busy_c (sb_rd_busy_c)
   );

   assign bus.rd_data  = rd_data_c;
   assign bus.rd_busy  = rd_busy_c;
   assign bus.busy_vec = busy_vec;

endmodule

// File: tb/tb_multiport_regfile_sb.sv
// Randomized bench for multiport_regfile_sb against an array/priority reference model.
module tb_multiport_regfile_sb;

   localparam int unsigned DW = 32;
   localparam int unsigned AW = 5;
   localparam int unsigned NR = 2;
   localparam int unsigned NW = 2;
   localparam int unsigned NREG = 1 << AW;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   multiport_regfile_sb_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW)) bus ();

   multiport_regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Reference state and the currently driven stimulus.
   logic [DW-1:0] ref_mem  [NREG];
   logic          ref_busy [NREG];
   logic [NW-1:0] drv_we;
   logic [AW-1:0] drv_wa [NW];
   logic [DW-1:0] drv_wd [NW];
   logic [AW-1:0] drv_ra [NR];
   logic          drv_ie;
   logic [AW-1:0] drv_ia;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_clear();
      for (int r = 0; r < int'(NREG); r++) begin
         ref_mem[r]  = '0;
         ref_busy[r] = 1'b0;
      end
   endtask

   // Expected read value: zero register, else forwarded write (highest port first), else array.
   function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] ra);
      if (ra == 0) return '0;
`ifdef REGFILE_BYPASS_EN
      for (int i = int'(NW) - 1; i >= 0; i--)
         if (drv_we[i] && drv_wa[i] == ra) return drv_wd[i];
`endif
      return ref_mem[ra];
   endfunction

   function automatic logic exp_busy(input logic [AW-1:0] ra);
      if (ra == 0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
      for (int i = 0; i < int'(NW); i++)
         if (drv_we[i] && drv_wa[i] == ra) return drv_ie && (drv_ia == ra);
`endif
      return ref_busy[ra];
   endfunction

   function automatic logic [NREG-1:0] exp_vec();
      logic [NREG-1:0] v;
      for (int r = 0; r < int'(NREG); r++) v[r] = ref_busy[r];
      return v;
   endfunction

   // Drive one cycle of stimulus, let it settle, compare all outputs with the model.
   task automatic apply(input logic [1:0] we, input logic [AW-1:0] wa0, input logic [DW-1:0] wd0,
                        input logic [AW-1:0] wa1, input logic [DW-1:0] wd1,
                        input logic [AW-1:0] ra0, input logic [AW-1:0] ra1,
                        input logic ie, input logic [AW-1:0] ia);
      drv_we = we; drv_wa[0] = wa0; drv_wd[0] = wd0; drv_wa[1] = wa1; drv_wd[1] = wd1;
      drv_ra[0] = ra0; drv_ra[1] = ra1; drv_ie = ie; drv_ia = ia;
      bus.wr_en   = we;
      bus.wr_addr = {wa1, wa0};
      bus.wr_data = {wd1, wd0};
      bus.rd_addr = {ra1, ra0};
      bus.iss_en  = ie;
      bus.iss_addr = ia;
      #1;
      for (int k = 0; k < int'(NR); k++) begin
         chk($sformatf("rd_data%0d@%0d", k, drv_ra[k]), 64'(bus.rd_data[k*DW +: DW]), 64'(exp_rd(drv_ra[k])));
         chk($sformatf("rd_busy%0d@%0d", k, drv_ra[k]), 64'(bus.rd_busy[k]), 64'(exp_busy(drv_ra[k])));
      end
      chk("busy_vec", 64'(bus.busy_vec), 64'(exp_vec()));
   endtask

   // Clock edge: commit writes (highest port wins) and scoreboard updates (issue beats clear).
   task automatic tick();
      logic [NREG-1:0] taken;
      logic set, clr;
      @(posedge clk);
      taken = '0;
      for (int i = int'(NW) - 1; i >= 0; i--) begin
         if (drv_we[i] && drv_wa[i] != 0 && !taken[drv_wa[i]]) begin
            ref_mem[drv_wa[i]] = drv_wd[i];
            taken[drv_wa[i]]   = 1'b1;
         end
      end
      for (int r = 1; r < int'(NREG); r++) begin
         set = drv_ie && (drv_ia == AW'(r));
         clr = 1'b0;
         for (int i = 0; i < int'(NW); i++) if (drv_we[i] && drv_wa[i] == AW'(r)) clr = 1'b1;
         if (set)      ref_busy[r] = 1'b1;
         else if (clr) ref_busy[r] = 1'b0;
      end
      @(negedge clk);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL timeout t=%0t", $time);
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1;
      model_clear();
      repeat (2) @(negedge clk);
      apply(2'b00, 0, 0, 0, 0, 5, 9, 1'b0, 0);
      chk("reset_vec", 64'(bus.busy_vec), 64'd0);
      rst = 1'b0;
      tick();

      // Port 0 write, visible next cycle (same cycle when forwarding).
      apply(2'b01, 5, 32'hDEADBEEF, 0, 0, 5, 0, 1'b0, 0);
`ifdef REGFILE_BYPASS_EN
      chk("wr5_same_cycle", 64'(bus.rd_data[DW-1:0]), 64'hDEADBEEF);
`endif
      tick();
      apply(2'b00, 0, 0, 0, 0, 5, 0, 1'b0, 0);
      chk("wr5_next_cycle", 64'(bus.rd_data[DW-1:0]), 64'hDEADBEEF);
      tick();

      // Register 0 ignores writes and issues.
      apply(2'b01, 0, 32'h1234, 0, 0, 0, 0, 1'b1, 0);
      chk("r0_rd_data", 64'(bus.rd_data[DW-1:0]), 64'd0);
      chk("r0_rd_busy", 64'(bus.rd_busy[0]), 64'd0);
      tick();
      apply(2'b00, 0, 0, 0, 0, 0, 0, 1'b0, 0);
      chk("r0_busy_vec", 64'(bus.busy_vec[0]), 64'd0);
      chk("r0_after", 64'(bus.rd_data[DW-1:0]), 64'd0);
      tick();

      // Both ports hit register 7: port 1 wins.
      apply(2'b11, 7, 32'h11, 7, 32'h22, 7, 0, 1'b0, 0);
      tick();
      apply(2'b00, 0, 0, 0, 0, 7, 7, 1'b0, 0);
      chk("dual_wr7", 64'(bus.rd_data[DW-1:0]), 64'h22);
      tick();

      // Scoreboard on register 9.
      apply(2'b00, 0, 0, 0, 0, 9, 0, 1'b1, 9);
      tick();
      apply(2'b01, 9, 32'h99, 0, 0, 9, 0, 1'b1, 9);
      chk("iss9_busy_vec", 64'(bus.busy_vec[9]), 64'd1);
      chk("iss9_rd_busy", 64'(bus.rd_busy[0]), 64'd1);
      tick();
      apply(2'b00, 0, 0, 0, 0, 9, 0, 1'b0, 0);
      chk("iss_wr9_keeps_busy", 64'(bus.busy_vec[9]), 64'd1);
      tick();
      apply(2'b01, 9, 32'h999, 0, 0, 9, 0, 1'b0, 0);
      tick();
      apply(2'b00, 0, 0, 0, 0, 9, 0, 1'b0, 0);
      chk("wr9_clears", 64'(bus.busy_vec[9]), 64'd0);
      chk("wr9_rd_busy", 64'(bus.rd_busy[0]), 64'd0);
      tick();

`ifdef REGFILE_BYPASS_EN
      apply(2'b01, 3, 32'hA5A5A5A5, 0, 0, 3, 0, 1'b0, 0);
      chk("bypass3_data", 64'(bus.rd_data[DW-1:0]), 64'hA5A5A5A5);
      chk("bypass3_busy", 64'(bus.rd_busy[0]), 64'd0);
      tick();
`endif

      // Random traffic on a narrowed address range to force collisions.
      for (int n = 0; n < 400; n++) begin
         apply(2'($urandom), AW'($urandom_range(0, 15)), $urandom, AW'($urandom_range(0, 15)), $urandom,
               AW'($urandom_range(0, 15)), AW'($urandom_range(0, 15)),
               ($urandom_range(0, 2) == 0), AW'($urandom_range(0, 15)));
         tick();
      end

      // Asynchronous reset mid-run after known nonzero state.
      apply(2'b01, 12, 32'hCAFEF00D, 0, 0, 0, 0, 1'b1, 13);
      tick();
      apply(2'b00, 0, 0, 0, 0, 12, 13, 1'b0, 0);
      chk("pre_rst_data", 64'(bus.rd_data[DW-1:0]), 64'hCAFEF00D);
      chk("pre_rst_busy", 64'(bus.rd_busy[1]), 64'd1);
      #2 rst = 1'b1;
      #1;
      chk("rst_busy_vec", 64'(bus.busy_vec), 64'd0);
      for (int a = 1; a < int'(NREG); a += 3) begin
         bus.rd_addr = {AW'(a), AW'(a + 1)};
         #1;
         chk($sformatf("rst_rd@%0d", a), 64'(bus.rd_data), 64'd0);
      end
      model_clear();
      @(negedge clk);
      // Write and issue while reset is held are lost.
      apply(2'b01, 12, 32'hFFFFFFFF, 0, 0, 0, 0, 1'b1, 12);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      apply(2'b00, 0, 0, 0, 0, 12, 13, 1'b0, 0);
      chk("rst_lost_wr", 64'(bus.rd_data[DW-1:0]), 64'd0);
      chk("rst_lost_iss", 64'(bus.busy_vec), 64'd0);
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
